// File: rtl/axi4_mem_pkg.sv
// ============================================================================
// Module      : axi4_mem_pkg
// Description : Shared types for the AXI4 burst memory slave: burst and
//               response encodings, write/read FSM state enums, and helpers
//               for burst legality and response merging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LAT  = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    // WRAP is only legal for 2/4/8/16 beats; the reserved encoding never is.
    function automatic logic burst_legal(input logic [1:0] burst, input logic [7:0] len);
        logic legal;
        legal = 1'b1;
        if (burst == BURST_RSVD) begin
            legal = 1'b0;
        end else if (burst == BURST_WRAP) begin
            legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        end
        return legal;
    endfunction

    // Per-beat response: an unmapped word outranks an illegal burst.
    function automatic logic [1:0] beat_resp(input logic legal, input logic in_range);
        logic [1:0] resp;
        resp = RESP_OKAY;
        if (!in_range) begin
            resp = RESP_DECERR;
        end else if (!legal) begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

    // Encodings are ordered by severity, so the worse response is the larger.
    function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
// ============================================================================
// Module      : axi4_burst_addr_gen
// Description : Combinational next-beat address for an AXI4 burst.
// Ports       : addr      - current beat byte address
//               burst     - burst type (FIXED/INCR/WRAP)
//               len       - burst length minus one
//               next_addr - byte address of the following beat (word aligned)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_burst_addr_gen
    import axi4_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        burst,
    input  logic [7:0]        len,
    output logic [ADDR_W-1:0] next_addr
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);

    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        aligned   = addr & ~ADDR_W'(BYTES - 1);
        incr      = aligned + ADDR_W'(BYTES);
        // (len+1)*BYTES-1 for the legal power-of-two wrap lengths
        wrap_mask = (ADDR_W'(len) << OFF) | ADDR_W'(BYTES - 1);
        next_addr = aligned;
        case (burst)
            BURST_INCR: next_addr = incr;
            BURST_WRAP: begin
                // Illegal wrap lengths still walk the burst; stepping linearly
                // keeps the error burst well-defined.
                if (burst_legal(burst, len)) begin
                    next_addr = (aligned & ~wrap_mask) | (incr & wrap_mask);
                end else begin
                    next_addr = incr;
                end
            end
            default: next_addr = aligned;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi4_burst_mem_slave.sv
// ============================================================================
// Module      : axi4_burst_mem_slave
// Description : AXI4 memory slave with FIXED/INCR/WRAP bursts, byte strobes,
//               independent read and write channels, optional read latency.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               S_AXI_AW*/W*/B*    - write address, data, response channels
//               S_AXI_AR*/R*       - read address and data channels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_burst_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 1,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------ write
    wr_state_e         wr_state;
    logic [ADDR_W-1:0] wr_addr, wr_next_addr;
    logic [7:0]        wr_len, wr_cnt;
    logic [1:0]        wr_burst, wr_acc, wr_beat, wr_beat_b;
    logic [ID_W-1:0]   wr_id;
    logic              wr_hs, wr_last_beat, mem_we;

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_addr (
        .addr(wr_addr), .burst(wr_burst), .len(wr_len), .next_addr(wr_next_addr)
    );

    always_comb begin
        wr_hs        = S_AXI_WREADY && S_AXI_WVALID;
        wr_last_beat = (wr_cnt == wr_len);
        wr_beat      = beat_resp(burst_legal(wr_burst, wr_len),
                                 (wr_addr >> OFF) < ADDR_W'(DEPTH));
        // A misplaced WLAST taints the B response but never blocks the write.
        wr_beat_b    = worse_resp(wr_beat, (S_AXI_WLAST != wr_last_beat) ? RESP_SLVERR : RESP_OKAY);
        mem_we       = wr_hs && (wr_beat == RESP_OKAY) && !rst;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[wr_addr[OFF +: IDX_W]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state      <= W_IDLE;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_id         <= '0;
            wr_addr       <= '0;
            wr_len        <= '0;
            wr_cnt        <= '0;
            wr_burst      <= '0;
            wr_acc        <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: if (S_AXI_AWVALID) begin
                    wr_id         <= S_AXI_AWID;
                    wr_addr       <= S_AXI_AWADDR;
                    wr_len        <= S_AXI_AWLEN;
                    wr_burst      <= S_AXI_AWBURST;
                    wr_cnt        <= '0;
                    wr_acc        <= RESP_OKAY;
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_WREADY  <= 1'b1;
                    wr_state      <= W_DATA;
                end
                W_DATA: if (wr_hs) begin
                    wr_addr <= wr_next_addr;
                    wr_cnt  <= wr_cnt + 8'd1;
                    wr_acc  <= worse_resp(wr_acc, wr_beat_b);
                    if (wr_last_beat) begin
                        S_AXI_WREADY <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BID    <= wr_id;
                        S_AXI_BRESP  <= worse_resp(wr_acc, wr_beat_b);
                        wr_state     <= W_RESP;
                    end
                end
                W_RESP: if (S_AXI_BREADY) begin
                    S_AXI_BVALID  <= 1'b0;
                    S_AXI_AWREADY <= 1'b1;
                    wr_state      <= W_IDLE;
                end
                default: begin
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b0;
                    S_AXI_BVALID  <= 1'b0;
                    wr_state      <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    rd_state_e         rd_state;
    logic [ADDR_W-1:0] rd_addr, rd_src_addr, rd_next_addr;
    logic [7:0]        rd_len, rd_src_len, rd_cnt;
    logic [1:0]        rd_burst, rd_src_burst, rd_beat;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] rd_beat_data;

    // rd_addr holds the address of the next beat to load; while idle the
    // request itself is looked up so a zero-latency read can load beat 0 on
    // the AR handshake edge.
    always_comb begin
        rd_src_addr  = (rd_state == R_IDLE) ? S_AXI_ARADDR  : rd_addr;
        rd_src_len   = (rd_state == R_IDLE) ? S_AXI_ARLEN   : rd_len;
        rd_src_burst = (rd_state == R_IDLE) ? S_AXI_ARBURST : rd_burst;
        rd_beat      = beat_resp(burst_legal(rd_src_burst, rd_src_len),
                                 (rd_src_addr >> OFF) < ADDR_W'(DEPTH));
        rd_beat_data = (rd_beat == RESP_OKAY) ? mem[rd_src_addr[OFF +: IDX_W]] : '0;
    end

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_addr (
        .addr(rd_src_addr), .burst(rd_src_burst), .len(rd_src_len), .next_addr(rd_next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state      <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            rd_addr       <= '0;
            rd_len        <= '0;
            rd_burst      <= '0;
            rd_cnt        <= '0;
            lat_cnt       <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (S_AXI_ARVALID) begin
                    S_AXI_ARREADY <= 1'b0;
                    S_AXI_RID     <= S_AXI_ARID;
                    rd_len        <= S_AXI_ARLEN;
                    rd_burst      <= S_AXI_ARBURST;
                    rd_cnt        <= '0;
                    if (RD_LAT == 0) begin
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RDATA  <= rd_beat_data;
                        S_AXI_RRESP  <= rd_beat;
                        S_AXI_RLAST  <= (S_AXI_ARLEN == 8'd0);
                        rd_addr      <= rd_next_addr;
                        rd_state     <= R_DATA;
                    end else begin
                        rd_addr  <= S_AXI_ARADDR;
                        lat_cnt  <= 4'(RD_LAT - 1);
                        rd_state <= R_LAT;
                    end
                end
                R_LAT: begin
                    if (lat_cnt == 4'd0) begin
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RDATA  <= rd_beat_data;
                        S_AXI_RRESP  <= rd_beat;
                        S_AXI_RLAST  <= (rd_len == 8'd0);
                        rd_addr      <= rd_next_addr;
                        rd_state     <= R_DATA;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                R_DATA: if (S_AXI_RREADY) begin
                    if (S_AXI_RLAST) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_RLAST   <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rd_state      <= R_IDLE;
                    end else begin
                        rd_cnt      <= rd_cnt + 8'd1;
                        S_AXI_RDATA <= rd_beat_data;
                        S_AXI_RRESP <= rd_beat;
                        S_AXI_RLAST <= ((rd_cnt + 8'd1) == rd_len);
                        rd_addr     <= rd_next_addr;
                    end
                end
                default: begin
                    S_AXI_ARREADY <= 1'b1;
                    S_AXI_RVALID  <= 1'b0;
                    S_AXI_RLAST   <= 1'b0;
                    rd_state      <= R_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4_burst_mem_slave.sv
// ============================================================================
// Module      : tb_axi4_burst_mem_slave
// Description : Directed self-checking bench for axi4_burst_mem_slave
//               (DATA_W=32, DEPTH=64, RD_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_burst_mem_slave;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 2;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [3:0]        wstrb;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0]     wd [16];
    logic [31:0]     rd_data [16];
    logic [31:0]     stall_data [16];
    bit              stall_seen [16];
    logic [1:0]      rd_resp [16];
    logic            rd_last [16];
    logic [ID_W-1:0] rd_id_seen;
    int              rd_first;
    int              rd_beats;

    always #5 clk = ~clk;

    axi4_burst_mem_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full write burst using wd[]; all driving and sampling on falling edges.
    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input bit early_last, input int bwait,
                            input logic [1:0] exp_resp, input logic [ID_W-1:0] exp_id);
        int guard;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        awvalid = 1'b0;
        check("wready_after_aw", {63'd0, wready}, 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wd[i];
            wstrb  = strb;
            wlast  = early_last ? (i == 0) : (i == int'(len));
            wvalid = 1'b1;
            guard  = 0;
            while (!wready && guard < 50) begin @(negedge clk); guard++; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("bvalid_after_last_w", {63'd0, bvalid}, 64'd1);
        check("bresp", {62'd0, bresp}, {62'd0, exp_resp});
        check("bid", {62'd0, bid}, {62'd0, exp_id});
        for (int j = 0; j < bwait; j++) begin
            @(negedge clk);
            check("b_hold", {61'd0, bvalid, bresp}, {61'd0, 1'b1, exp_resp});
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Read burst; captures each beat plus any value shown during a stall.
    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst, input bit toggle);
        int guard;
        int k;
        bit ph;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        arvalid  = 1'b0;
        k        = 1;
        ph       = 1'b1;
        rd_first = 0;
        rd_beats = 0;
        for (int i = 0; i < 16; i++) stall_seen[i] = 1'b0;
        while (rd_beats <= int'(len) && k < 200) begin
            if (rvalid) begin
                if (rd_first == 0) rd_first = k;
                rready = toggle ? ph : 1'b1;
                ph     = ~ph;
                if (rready) begin
                    rd_data[rd_beats] = rdata;
                    rd_resp[rd_beats] = rresp;
                    rd_last[rd_beats] = rlast;
                    rd_id_seen        = rid;
                    rd_beats++;
                end else begin
                    stall_data[rd_beats] = rdata;
                    stall_seen[rd_beats] = 1'b1;
                end
            end else begin
                rready = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        rready = 1'b0;
        check("read_beat_count", 64'(rd_beats), 64'(int'(len) + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_awready_arready", {62'd0, awready, arready}, 64'h3);
        check("rst_wready_bvalid_rvalid_rlast", {60'd0, wready, bvalid, rvalid, rlast}, 64'h0);
        check("rst_bid_rid_bresp_rresp", {56'd0, bid, rid, bresp, rresp}, 64'h0);
        check("rst_rdata", {32'd0, rdata}, 64'h0);

        // INCR write 0x10, then INCR read with RREADY toggling 1010
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
        do_write(2'd1, 32'h10, 8'd3, 2'b01, 4'hF, 1'b0, 0, 2'b00, 2'd1);
        do_read(2'd2, 32'h10, 8'd3, 2'b01, 1'b1);
        check("rd_latency", 64'(rd_first), 64'd4);
        check("rid", {62'd0, rd_id_seen}, 64'd2);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", {32'd0, rd_data[i]}, 64'(32'hA0 + i));
            check("incr_rlast_rresp", {61'd0, rd_last[i], rd_resp[i]}, {61'd0, (i == 3), 2'b00});
            if (i > 0) begin
                check("stall_seen", {63'd0, stall_seen[i]}, 64'd1);
                check("stall_rdata", {32'd0, stall_data[i]}, 64'(32'hA0 + i));
            end
        end

        // WRAP read 0x38 over words 0x30..0x3C = B0..B3
        for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + i;
        do_write(2'd0, 32'h30, 8'd3, 2'b01, 4'hF, 1'b0, 0, 2'b00, 2'd0);
        do_read(2'd3, 32'h38, 8'd3, 2'b10, 1'b0);
        check("wrap_b0", {32'd0, rd_data[0]}, 64'hB2);
        check("wrap_b1", {32'd0, rd_data[1]}, 64'hB3);
        check("wrap_b2", {32'd0, rd_data[2]}, 64'hB0);
        check("wrap_b3", {32'd0, rd_data[3]}, 64'hB1);
        check("wrap_last", {60'd0, rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 64'h1);

        // Illegal WRAP length: SLVERR, zero data on every beat
        do_read(2'd1, 32'h30, 8'd2, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("badwrap_rresp", {62'd0, rd_resp[i]}, 64'h2);
            check("badwrap_rdata", {32'd0, rd_data[i]}, 64'h0);
        end
        check("badwrap_rlast", {61'd0, rd_last[0], rd_last[1], rd_last[2]}, 64'h1);

        // Out-of-range write: DECERR, no aliasing onto word 0
        wd[0] = 32'h5A5A5A5A;
        do_write(2'd0, 32'h0, 8'd0, 2'b01, 4'hF, 1'b0, 0, 2'b00, 2'd0);
        wd[0] = 32'hDEADBEEF;
        do_write(2'd2, 32'h100, 8'd0, 2'b01, 4'hF, 1'b0, 2, 2'b11, 2'd2);
        do_read(2'd0, 32'h0, 8'd0, 2'b01, 1'b0);
        check("decerr_no_alias", {32'd0, rd_data[0]}, 64'h5A5A5A5A);
        check("single_rlast", {63'd0, rd_last[0]}, 64'd1);
        do_read(2'd0, 32'h100, 8'd0, 2'b01, 1'b0);
        check("decerr_rresp", {62'd0, rd_resp[0]}, 64'h3);
        check("decerr_rdata", {32'd0, rd_data[0]}, 64'h0);

        // Byte strobes
        wd[0] = 32'hFFFFFFFF;
        do_write(2'd0, 32'h40, 8'd0, 2'b01, 4'hF, 1'b0, 0, 2'b00, 2'd0);
        wd[0] = 32'h11223344;
        do_write(2'd0, 32'h40, 8'd0, 2'b01, 4'h5, 1'b0, 0, 2'b00, 2'd0);
        do_read(2'd0, 32'h40, 8'd0, 2'b01, 1'b0);
        check("wstrb_merge", {32'd0, rd_data[0]}, 64'hFF22FF44);

        // Misplaced WLAST: SLVERR held under BREADY stall, data still written
        wd[0] = 32'hE0; wd[1] = 32'hE1;
        do_write(2'd1, 32'h50, 8'd1, 2'b01, 4'hF, 1'b1, 2, 2'b10, 2'd1);
        do_read(2'd0, 32'h50, 8'd1, 2'b01, 1'b0);
        check("wlast_err_data0", {32'd0, rd_data[0]}, 64'hE0);
        check("wlast_err_data1", {32'd0, rd_data[1]}, 64'hE1);

        // FIXED bursts stay on one word
        wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2;
        do_write(2'd0, 32'h60, 8'd2, 2'b00, 4'hF, 1'b0, 0, 2'b00, 2'd0);
        do_read(2'd0, 32'h60, 8'd1, 2'b00, 1'b0);
        check("fixed_b0", {32'd0, rd_data[0]}, 64'hC2);
        check("fixed_b1", {32'd0, rd_data[1]}, 64'hC2);

        // Reset during beat 2 of an 8-beat write
        @(negedge clk);
        awid = 2'd3; awaddr = 32'h80; awlen = 8'd7; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hD0 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        wdata = 32'hD2; wvalid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wvalid = 1'b0;
        check("midrst_awready", {63'd0, awready}, 64'd1);
        check("midrst_bvalid_wready", {62'd0, bvalid, wready}, 64'd0);
        do_read(2'd0, 32'h80, 8'd1, 2'b01, 1'b0);
        check("midrst_beat0", {32'd0, rd_data[0]}, 64'hD0);
        check("midrst_beat1", {32'd0, rd_data[1]}, 64'hD1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_burst_mem_slave.md
AXI4_BURST_MEM_SLAVE -- requirements
Module: axi4_burst_mem_slave

Interface
REQ-001 Parameter DATA_W, default 32: data bus width; 32, 64 or 128.
REQ-002 Parameter ADDR_W, default 32: byte address width.
REQ-003 Parameter ID_W, default 1: transaction ID width.
REQ-004 Parameter DEPTH, default 1024: memory words of DATA_W; power of two.
REQ-005 Parameter RD_LAT, default 0: idle cycles, 0..15, inserted between AR handshake and first RVALID.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 S_AXI_AWID  in  ID_W  write ID.
REQ-009 S_AXI_AWADDR  in  ADDR_W  write start byte address.
REQ-010 S_AXI_AWLEN  in  8  beats minus one.
REQ-011 S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-012 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
REQ-013 S_AXI_WDATA  in  DATA_W  write data.
REQ-014 S_AXI_WSTRB  in  DATA_W/8  byte enables.
REQ-015 S_AXI_WLAST  in  1  last write beat.
REQ-016 S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
REQ-017 S_AXI_BID  out  ID_W  captured AWID.
REQ-018 S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-019 S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
REQ-020 S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST  in  ID_W, ADDR_W, 8, 2  read request, encodings as AW.
REQ-021 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
REQ-022 S_AXI_RID  out  ID_W  captured ARID.
REQ-023 S_AXI_RDATA  out  DATA_W  read data.
REQ-024 S_AXI_RRESP  out  2  encoding as BRESP.
REQ-025 S_AXI_RLAST  out  1  last read beat.
REQ-026 S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.

Function
REQ-027 Write FSM W_IDLE -> W_DATA on AW handshake -> W_RESP after final counted beat -> W_IDLE on B handshake; AWREADY = 1 only in W_IDLE; WREADY = 1 only in W_DATA; one write outstanding.
REQ-028 Read FSM R_IDLE -> R_LAT (RD_LAT cycles; skipped when 0) -> R_DATA -> R_IDLE on handshake of beat ARLEN; ARREADY = 1 only in R_IDLE; read and write paths fully independent.
REQ-029 Latency: AW handshake at edge N gives WREADY = 1 from cycle N+1; last W handshake at N gives BVALID at N+1; AR handshake at N gives RVALID at N+1+RD_LAT.
REQ-030 Beat address: FIXED holds start; INCR adds DATA_W/8; WRAP adds DATA_W/8 and wraps within aligned (LEN+1)*DATA_W/8 block; low address bits below DATA_W/8 ignored.
REQ-031 WRAP with LEN not in {1,3,7,15}, or burst type 11, gives SLVERR; burst still runs LEN+1 beats; no memory write; reads return zero.
REQ-032 Word index = address bits above byte offset, modulo nothing: any beat with index >= DEPTH gives DECERR; write suppressed, RDATA = 0; DECERR overrides SLVERR.
REQ-033 Writes update only bytes whose WSTRB bit = 1.
REQ-034 WLAST asserted before beat AWLEN, or absent on beat AWLEN, gives BRESP = SLVERR; beat count alone ends the burst; data still written.
REQ-035 BRESP = worst response of the burst; RRESP per beat.
REQ-036 BVALID, BID, BRESP and RVALID, RDATA, RRESP, RLAST, RID held stable while VALID = 1 and READY = 0.
REQ-037 Same-cycle read and write to one word: read returns pre-write contents; write commits.

Reset
REQ-038 rst = 1 at a rising edge: both FSMs to IDLE, AWREADY = ARREADY = 1, WREADY = BVALID = RVALID = RLAST = 0, BID = RID = BRESP = RRESP = 0, RDATA = 0; in-flight bursts abandoned; memory contents retained.

Structure
REQ-039 Package axi4_mem_pkg holds burst enum, response codes, write and read FSM state enums, wrap-length check function.
REQ-040 Sub-module axi4_burst_addr_gen computes next beat address; instantiated once per path.

Verification
REQ-041 INCR write AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, WSTRB=F -> BRESP=00; INCR read same address -> 0xA0..0xA3, RLAST on beat 3 only.
REQ-042 WRAP read ARADDR=0x38, ARLEN=3, DATA_W=32 -> words 0x38,0x3C,0x30,0x34; ARLEN=2 WRAP -> RRESP=10 all beats, RDATA=0.
REQ-043 Write to byte address DEPTH*4 -> BRESP=11, memory unchanged; WSTRB=0x5 over 0xFFFFFFFF with 0x11223344 -> readback 0xFF22FF44.
REQ-044 RD_LAT=3, RREADY toggled 1010 -> first RVALID 4 cycles after AR handshake, RDATA stable during stalls.
REQ-045 rst pulsed mid-write at beat 2 of 8 -> AWREADY=1, BVALID=0 next cycle; beats 0-1 retained in memory.
